// File: rtl/seq_detect_prog_if.sv
// Bus bundle for seq_detect_prog: serial input, runtime config and detector outputs.
// Handshake: bit_in is consumed on any rising edge where bit_vld is high; there is
// no backpressure (the detector accepts one bit per cycle). cfg_load, cnt_clr and
// overlap_en are single-cycle level qualifiers sampled on the same edge.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);
  logic               bit_in;
  logic               bit_vld;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               overlap_en;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;
  logic [1:0]         state_dbg;

  modport master (
    output bit_in, bit_vld, cfg_load, cfg_pattern, cfg_len, overlap_en, cnt_clr,
    input  match, match_cnt, armed, state_dbg
  );

  modport slave (
    input  bit_in, bit_vld, cfg_load, cfg_pattern, cfg_len, overlap_en, cnt_clr,
    output match, match_cnt, armed, state_dbg
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap / non-overlap modes.
// Optional feature macro: SEQDET_COUNT_EN -- when defined, a saturating match
// counter drives match_cnt and honours cnt_clr; when undefined match_cnt is 0.
module seq_detect_prog #(
  parameter int               MAX_LEN = 8,
  parameter int               LEN_W   = $clog2(MAX_LEN + 1),
  parameter int               CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = 'b1101,
  parameter int               RST_LEN = 4
) (
  input logic              clk,
  input logic              rst,
  seq_detect_prog_if.slave det
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_FILL     = 2'd1,
    ST_ARMED    = 2'd2
  } state_e;

  localparam state_e ST_RESET = (RST_LEN == 0) ? ST_DISABLED : ST_FILL;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   cfg_len_clamped;
  logic               fill_full;
  logic               hit;

  // Datapath helpers: history including the current bit, saturating fill and the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hist_shift      = {hist_q[MAX_LEN-2:0], det.bit_in};
    fill_inc        = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
    fill_full       = (fill_inc >= len_q);
    hit             = det.bit_vld && fill_full &&
                      (((hist_shift ^ pat_q) & len_mask) == '0);
    cfg_len_clamped = (det.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : det.cfg_len;
  end

  // Next-state logic: cfg_load wins over bit_vld and discards the current bit.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    len_d   = len_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (det.cfg_load) begin
      pat_d   = det.cfg_pattern;
      len_d   = cfg_len_clamped;
      hist_d  = '0;
      fill_d  = '0;
      state_d = (cfg_len_clamped == '0) ? ST_DISABLED : ST_FILL;
    end else begin
      case (state_q)
        ST_FILL, ST_ARMED: begin
          if (det.bit_vld) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (hit) begin
              match_d = 1'b1;
              if (det.overlap_en) begin
                state_d = ST_ARMED;
              end else begin
                // Non-overlap: the matched bits may not seed the next match.
                hist_d  = '0;
                fill_d  = '0;
                state_d = ST_FILL;
              end
            end else begin
              state_d = fill_full ? ST_ARMED : ST_FILL;
            end
          end
        end
        default: begin
          // DISABLED (and the unused encoding) ignore the serial stream.
          state_d = ST_DISABLED;
        end
      endcase
    end
  end

  // State and datapath registers, restored to the reset configuration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RESET;
      hist_q  <= '0;
      pat_q   <= RST_PAT;
      len_q   <= LEN_W'(RST_LEN);
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign det.match     = match_q;
  assign det.armed     = (state_q == ST_ARMED);
  assign det.state_dbg = state_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating counter; a coincident clear and match leaves a count of one.
  always_comb begin
    cnt_d = cnt_q;
    if (match_d) begin
      if (det.cnt_clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (det.cnt_clr) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign det.match_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = det.cnt_clr;
  assign det.match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus random traffic,
// checked every cycle against a bit-queue reference model through an expected queue.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 2;
  localparam int EW      = CNT_W + 2;
`ifdef SEQDET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) det ();

  seq_detect_prog #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
    .RST_PAT(8'b0000_1101), .RST_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .det(det)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int seen_matches = 0;

  // reference model: the valid bits seen since the last flush, oldest first
  bit                 bits_q[$];
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  int                 m_cnt;
  logic               ovl;

  task automatic check_val(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset(output logic [EW-1:0] e);
    m_pat = 8'b0000_1101;
    m_len = 4;
    m_cnt = 0;
    bits_q.delete();
    e = '0;
  endtask

  task automatic model_step(input logic b, input logic vld, input logic load,
                            input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                            input logic clr, output logic [EW-1:0] e);
    logic m;
    logic ok;
    logic arm;
    m = 1'b0;
    if (load) begin
      m_pat = p;
      m_len = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
      bits_q.delete();
    end else if (vld && m_len != 0) begin
      bits_q.push_back(b);
      if (bits_q.size() > MAX_LEN) void'(bits_q.pop_front());
      if (bits_q.size() >= m_len) begin
        // the last m_len bits, oldest first, must read pattern bit m_len-1 down to 0
        ok = 1'b1;
        for (int k = 0; k < m_len; k++) begin
          if (bits_q[bits_q.size() - m_len + k] != m_pat[m_len - 1 - k]) ok = 1'b0;
        end
        m = ok;
      end
      if (m && !ovl) bits_q.delete();
    end
    if (CNT_ON) begin
      if (m) m_cnt = clr ? 1 : ((m_cnt + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_cnt + 1);
      else if (clr) m_cnt = 0;
    end
    arm = (m_len != 0) && (bits_q.size() >= m_len);
    e = {m, CNT_W'(m_cnt), arm};
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic b, input logic vld, input logic load,
                       input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                       input logic clr);
    logic [EW-1:0] e;
    @(negedge clk);
    rst             = 1'b1;
    det.bit_in      = b;
    det.bit_vld     = vld;
    det.cfg_load    = load;
    det.cfg_pattern = p;
    det.cfg_len     = l;
    det.overlap_en  = ovl;
    det.cnt_clr     = clr;
    model_step(b, vld, load, p, l, clr, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    logic [EW-1:0] e;
    @(negedge clk);
    rst          = 1'b0;
    det.bit_vld  = 1'b0;
    det.cfg_load = 1'b0;
    det.cnt_clr  = 1'b0;
    model_reset(e);
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    drive(b, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l);
    drive(1'b0, 1'b0, 1'b1, p, l, 1'b0);
  endtask

  task automatic send_stream(input logic [15:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(s[i]);
  endtask

  // idle cycles, then wait until the monitor has consumed the last expectation
  task automatic drain();
    repeat (2) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (det.match === 1'b1) seen_matches++;
      check_val("match", int'(det.match), int'(e[EW-1]));
      check_val("match_cnt", int'(det.match_cnt), int'(e[CNT_W:1]));
      check_val("armed", int'(det.armed), int'(e[0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    logic [MAX_LEN-1:0] p;
    rst = 1'b0;
    ovl = 1'b1;
    det.bit_in = 1'b0; det.bit_vld = 1'b0; det.cfg_load = 1'b0;
    det.cfg_pattern = '0; det.cfg_len = '0; det.overlap_en = 1'b1; det.cnt_clr = 1'b0;

    // reset defaults, overlapping 1101101 -> matches after bits 4 and 7
    do_reset();
    ovl = 1'b1;
    base = seen_matches;
    send_stream(16'b1101101, 7);
    drain();
    check_val("overlap_matches", seen_matches - base, 2);
    check_val("overlap_cnt", int'(det.match_cnt), CNT_ON ? 2 : 0);

    // non-overlapping: the second 1101 shares a bit, so only one match
    do_reset();
    ovl = 1'b0;
    base = seen_matches;
    send_stream(16'b1101101, 7);
    drain();
    check_val("nonoverlap_matches", seen_matches - base, 1);

    // 8-bit pattern fed with gaps, then back-to-back
    ovl = 1'b1;
    p = 8'b1011_0011;
    load_cfg(p, 4'd8);
    base = seen_matches;
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      while ($urandom_range(0, 2) == 0) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, '0, 1'b0);
      send_bit(p[i]);
    end
    for (int i = MAX_LEN - 1; i >= 0; i--) send_bit(p[i]);
    drain();
    check_val("len8_matches", seen_matches - base, 2);
    check_val("len8_armed", int'(det.armed), 1);

    // len 0 disables detection
    load_cfg(8'hff, 4'd0);
    base = seen_matches;
    repeat (20) send_bit(1'($urandom_range(0, 1)));
    drain();
    check_val("disabled_matches", seen_matches - base, 0);
    check_val("disabled_armed", int'(det.armed), 0);

    // oversize length clamps to MAX_LEN
    p = 8'b1110_0101;
    load_cfg(p, 4'd12);
    base = seen_matches;
    for (int i = MAX_LEN - 1; i >= 0; i--) send_bit(p[i]);
    drain();
    check_val("clamp_matches", seen_matches - base, 1);

    // counter saturation and clear coincident with a match
    load_cfg(8'h01, 4'd1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    repeat (5) send_bit(1'b1);
    drain();
    check_val("cnt_saturate", int'(det.match_cnt), CNT_ON ? 3 : 0);
    drive(1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    drain();
    check_val("cnt_clr_with_match", int'(det.match_cnt), CNT_ON ? 1 : 0);

    // reset in the middle of a partial 110 discards history
    do_reset();
    ovl = 1'b1;
    send_stream(16'b110, 3);
    do_reset();
    base = seen_matches;
    send_bit(1'b1);
    drain();
    check_val("reset_partial_matches", seen_matches - base, 0);
    send_stream(16'b1101, 4);
    drain();
    check_val("after_reset_matches", seen_matches - base, 1);

    // random traffic with occasional reconfiguration, clears and resets
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [LEN_W-1:0] l;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) ovl = ~ovl;
      if (r == 99) begin
        do_reset();
      end else if (r < 4) begin
        l = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15)) : LEN_W'($urandom_range(1, 4));
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
              MAX_LEN'($urandom), l, 1'($urandom_range(0, 1)));
      end else begin
        drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, '0, '0,
              ($urandom_range(0, 19) == 0));
      end
    end
    drain();
    check_val("exp_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
